// File: rtl/usb_slave_fifo_writer_if.sv
// Bundles the arbiter-side word stream and the USB slave-FIFO write pins.
interface usb_slave_fifo_writer_if;
  logic [15:0] in_din;
  logic        in_en;
  logic        in_almost_full;
  logic        usb_flagb_n;
  logic [15:0] usb_fd;
  logic        usb_slwr_n;
  logic        usb_pktend_n;
  logic [1:0]  usb_fifoadr;
  logic        usb_slcs_n;

  modport slave (
    input  in_din, in_en, usb_flagb_n,
    output in_almost_full, usb_fd, usb_slwr_n, usb_pktend_n, usb_fifoadr, usb_slcs_n
  );

  modport master (
    output in_din, in_en, usb_flagb_n,
    input  in_almost_full, usb_fd, usb_slwr_n, usb_pktend_n, usb_fifoadr, usb_slcs_n
  );
endinterface

// File: rtl/usb_slave_fifo_writer.sv
// Elastic buffer between the channel arbiter and the USB slave FIFO; writes words
// out as the endpoint allows and commits short packets with PKTEND after idling.
module usb_slave_fifo_writer #(
  parameter int          BUF_AW        = 4,
  parameter int          PKT_WORDS     = 256,
  parameter int          FLUSH_TIMEOUT = 4096,
  parameter logic [1:0]  EP_ADDR       = 2'b10
) (
  input  logic                     clk,
  input  logic                     rst,
  usb_slave_fifo_writer_if.slave   bus,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int DEPTH = 2 ** BUF_AW;
  localparam int PW    = $clog2(PKT_WORDS);
  localparam int TW    = $clog2(FLUSH_TIMEOUT);
  localparam logic [BUF_AW:0] AF_LEVEL  = (BUF_AW + 1)'(DEPTH - 2);
  localparam logic [BUF_AW:0] PTR_ONE   = (BUF_AW + 1)'(1);
  localparam logic [PW-1:0]   PKT_LAST  = PW'(PKT_WORDS - 1);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(FLUSH_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, PKTEND} state_t;

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [BUF_AW:0] wr_ptr, rd_ptr, count, count_next;
  logic            empty, full, pop, push, drop, timeout;
  logic [PW-1:0]   pkt_cnt;
  logic [TW-1:0]   idle_timer;
  logic [15:0]     head;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[BUF_AW] != rd_ptr[BUF_AW]) &&
                   (wr_ptr[BUF_AW-1:0] == rd_ptr[BUF_AW-1:0]);
  assign head    = mem[rd_ptr[BUF_AW-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
  assign pop     = (state == WRITE) && !empty && bus.usb_flagb_n;
  assign push    = bus.in_en && (!full || pop);
  assign drop    = bus.in_en && full && !pop;
  assign count_next = count + (push ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);

  // Incoming data on the timeout cycle takes priority over the flush.
  assign timeout = (state == IDLE) && empty && !bus.in_en && (pkt_cnt != '0) &&
                   (idle_timer == TIMER_MAX);

  assign bus.usb_fifoadr = EP_ADDR;
  assign bus.usb_slcs_n  = 1'b0;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[BUF_AW-1:0]] <= bus.in_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      overflow           <= 1'b0;
      drop_cnt           <= '0;
      bus.in_almost_full <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
      bus.in_almost_full <= (count_next >= AF_LEVEL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.usb_slwr_n   <= 1'b1;
      bus.usb_pktend_n <= 1'b1;
      bus.usb_fd       <= '0;
      pkt_cnt          <= '0;
      idle_timer       <= '0;
    end else begin
      bus.usb_slwr_n   <= !pop;
      bus.usb_pktend_n <= 1'b1;
      if (pop) begin
        bus.usb_fd <= head;
        pkt_cnt    <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + PW'(1);
      end

      if ((state == IDLE) && empty && !bus.in_en && (pkt_cnt != '0))
        idle_timer <= (idle_timer == TIMER_MAX) ? idle_timer : idle_timer + TW'(1);
      else
        idle_timer <= '0;

      case (state)
        IDLE: begin
          if (!empty || bus.in_en)
            state <= WRITE;
          else if (timeout)
            state <= PKTEND;
        end
        WRITE: begin
          if (count_next == '0)
            state <= IDLE;
        end
        PKTEND: begin
          if (bus.usb_flagb_n) begin
            bus.usb_pktend_n <= 1'b0;
            pkt_cnt          <= '0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_slave_fifo_writer.sv
// Directed bench for usb_slave_fifo_writer: streaming, stalls/overflow, short-packet
// flush timing, timeout race and mid-stream reset.
module tb_usb_slave_fifo_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        overflow;
  logic [15:0] drop_cnt;

  usb_slave_fifo_writer_if bus();

  usb_slave_fifo_writer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;
  int cycle_num    = 0;
  int strobe_count = 0;
  int pktend_count = 0;
  int first_strobe = -1;
  int first_en     = 0;
  int base_s       = 0;
  int base_p       = 0;
  logic [15:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Output monitor: every write strobe must carry the next expected word in order.
  task automatic sample_outputs();
    logic [15:0] exp_word;
    if (!rst) begin
      if (bus.usb_slwr_n === 1'b0) begin
        strobe_count++;
        if (first_strobe < 0)
          first_strobe = cycle_num;
        assert_count++;
        assert (exp_q.size() != 0) else begin
          fail_count++;
          $error("[TB] FAIL strobe_extra observed fd=0x%0h expected no write", bus.usb_fd);
        end
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          checkOutput("fd_order", 32'(bus.usb_fd), 32'(exp_word));
        end
      end
      if (bus.usb_pktend_n === 1'b0) begin
        pktend_count++;
        checkOutput("slwr_during_pktend", 32'(bus.usb_slwr_n), 32'd1);
      end
    end
  endtask

  task automatic tick();
    cycle_num++;
    @(negedge clk);
    sample_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++)
      tick();
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] din, input logic keep);
    bus.in_en  = en;
    bus.in_din = din;
    if (en && keep)
      exp_q.push_back(din);
    tick();
    bus.in_en = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_en       = 1'b0;
    bus.in_din      = '0;
    bus.usb_flagb_n = 1'b1;
    #2;
    checkOutput("rst_slwr_n",   32'(bus.usb_slwr_n),     32'd1);
    checkOutput("rst_pktend_n", 32'(bus.usb_pktend_n),   32'd1);
    checkOutput("rst_fd",       32'(bus.usb_fd),         32'd0);
    checkOutput("rst_fifoadr",  32'(bus.usb_fifoadr),    32'd2);
    checkOutput("rst_slcs_n",   32'(bus.usb_slcs_n),     32'd0);
    checkOutput("rst_af",       32'(bus.in_almost_full), 32'd0);
    checkOutput("rst_overflow", 32'(overflow),           32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt),           32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 600-word back-to-back stream, then an 88-word short packet flush
    $display("[TB] stream 600 words");
    first_en     = cycle_num + 1;
    first_strobe = -1;
    base_s       = strobe_count;
    base_p       = pktend_count;
    for (int i = 0; i < 600; i++)
      applyStimulus(1'b1, 16'(i), 1'b1);
    wait_cycles(10);
    checkOutput("t1_strobes",  32'(strobe_count - base_s), 32'd600);
    checkOutput("t1_latency",  32'(first_strobe - first_en), 32'd2);
    checkOutput("t1_pkt_cnt",  32'(dut.pkt_cnt), 32'd88);
    checkOutput("t1_drained",  32'(exp_q.size()), 32'd0);
    wait_cycles(4080);
    checkOutput("t1_no_early_pktend", 32'(pktend_count - base_p), 32'd0);
    wait_cycles(20);
    checkOutput("t1_one_pktend", 32'(pktend_count - base_p), 32'd1);
    checkOutput("t1_pkt_cnt_clr", 32'(dut.pkt_cnt), 32'd0);
    checkOutput("t1_overflow",  32'(overflow), 32'd0);

    // 30 words while the endpoint is full: 16 buffered, 14 dropped
    $display("[TB] full-flag stall with overflow");
    bus.usb_flagb_n = 1'b0;
    base_s = strobe_count;
    base_p = pktend_count;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 16'h1000 + 16'(i), (i < 16));
      if (i == 12) checkOutput("t2_af_at_13", 32'(bus.in_almost_full), 32'd0);
      if (i == 13) checkOutput("t2_af_at_14", 32'(bus.in_almost_full), 32'd1);
    end
    checkOutput("t2_drop_cnt", 32'(drop_cnt), 32'd14);
    checkOutput("t2_overflow", 32'(overflow), 32'd1);
    checkOutput("t2_no_write_stalled", 32'(strobe_count - base_s), 32'd0);
    bus.usb_flagb_n = 1'b1;
    wait_cycles(1);
    checkOutput("t2_no_write_yet", 32'(strobe_count - base_s), 32'd0);
    wait_cycles(16);
    checkOutput("t2_burst_no_gaps", 32'(strobe_count - base_s), 32'd16);
    checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_af_clear", 32'(bus.in_almost_full), 32'd0);
    wait_cycles(4200);
    checkOutput("t2_flush_pktend", 32'(pktend_count - base_p), 32'd1);

    // Exactly one full packet: no PKTEND ever
    $display("[TB] exact full packet");
    base_s = strobe_count;
    base_p = pktend_count;
    for (int i = 0; i < 256; i++)
      applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b1);
    wait_cycles(4200);
    checkOutput("t3_strobes",   32'(strobe_count - base_s), 32'd256);
    checkOutput("t3_no_pktend", 32'(pktend_count - base_p), 32'd0);
    checkOutput("t3_pkt_cnt",   32'(dut.pkt_cnt), 32'd0);

    // PKTEND held off by the full flag right as the timeout fires
    $display("[TB] pktend delayed by full flag");
    base_s = strobe_count;
    base_p = pktend_count;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b1);
    wait_cycles(4096);
    bus.usb_flagb_n = 1'b0;
    wait_cycles(10);
    checkOutput("t4_pktend_held", 32'(pktend_count - base_p), 32'd0);
    bus.usb_flagb_n = 1'b1;
    wait_cycles(3);
    checkOutput("t4_pktend_once", 32'(pktend_count - base_p), 32'd1);
    checkOutput("t4_strobes",     32'(strobe_count - base_s), 32'd5);

    // Second word lands on the exact timeout cycle: data wins
    $display("[TB] data on timeout cycle");
    base_s = strobe_count;
    base_p = pktend_count;
    applyStimulus(1'b1, 16'h4000, 1'b1);
    wait_cycles(4096);
    applyStimulus(1'b1, 16'h4001, 1'b1);
    wait_cycles(20);
    checkOutput("t5_strobes",   32'(strobe_count - base_s), 32'd2);
    checkOutput("t5_no_pktend", 32'(pktend_count - base_p), 32'd0);
    checkOutput("t5_pkt_cnt",   32'(dut.pkt_cnt), 32'd2);
    wait_cycles(4073);
    checkOutput("t5_no_early_pktend", 32'(pktend_count - base_p), 32'd0);
    wait_cycles(10);
    checkOutput("t5_late_pktend", 32'(pktend_count - base_p), 32'd1);

    // Reset mid-stream with 8 words buffered
    $display("[TB] reset mid-stream");
    bus.usb_flagb_n = 1'b0;
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 16'h5000 + 16'(i), 1'b1);
    bus.usb_flagb_n = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'h5008 + 16'(i), 1'b1);
    checkOutput("t6_slwr_before", 32'(bus.usb_slwr_n), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("t6_slwr_n",   32'(bus.usb_slwr_n),     32'd1);
    checkOutput("t6_pktend_n", 32'(bus.usb_pktend_n),   32'd1);
    checkOutput("t6_fd",       32'(bus.usb_fd),         32'd0);
    checkOutput("t6_overflow", 32'(overflow),           32'd0);
    checkOutput("t6_drop_cnt", 32'(drop_cnt),           32'd0);
    checkOutput("t6_af",       32'(bus.in_almost_full), 32'd0);
    checkOutput("t6_pkt_cnt",  32'(dut.pkt_cnt),        32'd0);
    exp_q.delete();
    base_s = strobe_count;
    base_p = pktend_count;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(20);
    checkOutput("t6_no_writes", 32'(strobe_count - base_s), 32'd0);
    checkOutput("t6_no_pktend", 32'(pktend_count - base_p), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule

// File: doc/usb_slave_fifo_writer.md
Name: usb_slave_fifo_writer

Overview:
- Stage directly downstream of the two-channel FIFO arbiter. Consumes its 16-bit word stream (din + enable strobe) and drives the USB controller's slave-FIFO write interface.
- Contains a small elastic buffer that absorbs USB full-flag stalls.
- Tracks words written per USB packet and commits short packets with PKTEND after an idle timeout, so the host never waits on partial data.

Parameters:
BUF_AW, 4, address width of internal buffer; depth = 2**BUF_AW words (16)
PKT_WORDS, 256, words per full USB packet (512-byte endpoint)
FLUSH_TIMEOUT, 4096, idle cycles before a partial packet is committed
EP_ADDR, 2'b10, constant value driven on usb_fifoadr (EP6)

Ports:
clk  in  1  system clock, same as the USB interface clock (IFCLK)
rst  in  1  asynchronous active-high reset
in_din  in  16  data word from the channel arbiter
in_en  in  1  in_din valid this cycle; no handshake back, one word per cycle max
in_almost_full  out  1  registered; 1 when buffer free slots <= 2 (advisory to upstream)
usb_flagb_n  in  1  USB endpoint full flag, active low (0 = full)
usb_fd  out  16  data to USB FIFO, registered
usb_slwr_n  out  1  write strobe, active low, registered
usb_pktend_n  out  1  packet-end strobe, active low, registered
usb_fifoadr  out  2  endpoint select, constant EP_ADDR
usb_slcs_n  out  1  chip select, constant 0 after reset
overflow  out  1  sticky; set when a word is dropped
drop_cnt  out  16  count of dropped words, saturates at 16'hFFFF

Behaviour:
- Reset (async, rst=1), all values effective immediately:
  - usb_slwr_n=1, usb_pktend_n=1, usb_fd=0, usb_fifoadr=EP_ADDR, usb_slcs_n=0.
  - in_almost_full=0, overflow=0, drop_cnt=0.
  - Buffer emptied; pkt_cnt=0; idle timer=0; state=IDLE.
  - Reset mid-packet discards buffered words; no PKTEND is issued.
- Buffer: synchronous FIFO with BUF_AW+1-bit pointers; full/empty from the pointer MSB compare.
  - in_en=1 and not full: write.
  - in_en=1 and full: word dropped, overflow<=1, drop_cnt+1 (saturating).
  - Push and pop in the same cycle are both allowed, including when full (pop frees the slot first, so the word is written, not dropped).
- FSM states: IDLE, WRITE, PKTEND.
  - IDLE -> WRITE when buffer non-empty.
  - IDLE -> PKTEND when pkt_cnt!=0 and idle timer reaches FLUSH_TIMEOUT-1.
  - WRITE, in any cycle with buffer non-empty and usb_flagb_n=1: pop the head word; next cycle usb_fd=head and usb_slwr_n=0. Latency from in_en to usb_slwr_n low is 2 cycles when the buffer is empty and the flag is not full.
  - WRITE with usb_flagb_n=0: no pop; usb_slwr_n=1 next cycle; usb_fd holds its last value.
  - WRITE -> IDLE when the buffer goes empty with no push that cycle.
  - PKTEND: waits while usb_flagb_n=0. With usb_flagb_n=1, drive usb_pktend_n=0 for exactly one cycle, clear pkt_cnt, go to IDLE. usb_slwr_n and usb_pktend_n are never low in the same cycle.
- pkt_cnt (width clog2(PKT_WORDS)):
  - Increments on each issued write.
  - At PKT_WORDS-1 + write it wraps to 0; no PKTEND for a full packet.
- Idle timer:
  - Counts only in IDLE with buffer empty and pkt_cnt!=0; cleared otherwise.
  - Saturates at FLUSH_TIMEOUT-1.
  - in_en arriving in the same cycle the timeout would fire: data wins; go to WRITE, timer cleared, no PKTEND.
- in_almost_full: registered from the post-update occupancy.

Test Plan:
- Stream 600 words (0x0000..0x0257) back-to-back, usb_flagb_n=1 -> 600 slwr_n low cycles, fd in order, first strobe 2 cycles after first in_en; pkt_cnt wraps after 256 and 512; after 4096 idle cycles one pktend_n pulse (88-word short packet); overflow=0.
- Hold usb_flagb_n=0 for 30 cycles during a continuous stream -> 16 words buffered; in_almost_full=1 at 14 entries; exactly 14 words dropped (30-16); drop_cnt=14, overflow=1; after flag release the buffered words emerge in order with no gaps.
- Push exactly 256 words then go idle -> no pktend_n pulse ever; pkt_cnt=0.
- Push 5 words, idle until the timer reaches 4095, then flagb_n=0 for 10 cycles -> pktend_n delayed until the flag is released, then a single 1-cycle pulse.
- Push 1 word, then another word on the exact timeout cycle -> no PKTEND; second word written; PKTEND follows 4096 cycles later.
- Assert rst mid-stream with 8 words buffered -> slwr_n=1 immediately; no further writes or pktend; all counters 0.
